// File: rtl/ps2_frame_receiver.sv
// PS/2 device-to-host frame receiver: start, 8 data bits LSB first, odd parity, stop.
// Optional macro PS2_CLK_FILTER_EN adds a low-time filter on the PS/2 clock edge detector.
module ps2_frame_receiver #(
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int FILTER_CYCLES  = 8
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       CLK_MOUSE_IN,
    input  logic       DATA_MOUSE_IN,
    input  logic       READ_ENABLE,
    output logic [7:0] BYTE_READ,
    output logic [1:0] BYTE_ERROR_CODE,
    output logic       BYTE_READY,
    output logic       TIMEOUT,
    output logic       BUSY
);

    localparam int TW = $clog2(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic          clk_meta, clk_sync, data_meta, data_sync;
    logic          fe_raw, fe_q, fe_data_q;
    logic [7:0]    shift_q, shift_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [TW-1:0] to_cnt_q, to_cnt_d;
    logic          parity_q, parity_d;
    logic [7:0]    byte_d;
    logic [1:0]    err_d;
    logic          ready_d, timeout_d;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            clk_meta  <= 1'b1;
            clk_sync  <= 1'b1;
            data_meta <= 1'b1;
            data_sync <= 1'b1;
        end else begin
            clk_meta  <= CLK_MOUSE_IN;
            clk_sync  <= clk_meta;
            data_meta <= DATA_MOUSE_IN;
            data_sync <= data_meta;
        end
    end

`ifdef PS2_CLK_FILTER_EN
    localparam int FW = $clog2(FILTER_CYCLES + 1);
    logic [FW-1:0] low_cnt_q;

    // Saturates at FILTER_CYCLES so a long low produces exactly one edge.
    always_ff @(posedge CLK) begin
        if (RESET || clk_sync)
            low_cnt_q <= '0;
        else if (low_cnt_q != FW'(FILTER_CYCLES))
            low_cnt_q <= low_cnt_q + FW'(1);
    end

    assign fe_raw = ~clk_sync && (low_cnt_q == FW'(FILTER_CYCLES - 1));
`else
    logic clk_prev;

    always_ff @(posedge CLK) begin
        if (RESET)
            clk_prev <= 1'b1;
        else
            clk_prev <= clk_sync;
    end

    assign fe_raw = clk_prev & ~clk_sync;
`endif

    // Edge register: the edge and the data level seen in the edge cycle travel together.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            fe_q      <= 1'b0;
            fe_data_q <= 1'b0;
        end else begin
            fe_q      <= fe_raw;
            fe_data_q <= data_sync;
        end
    end

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        to_cnt_d  = to_cnt_q;
        parity_d  = parity_q;
        byte_d    = BYTE_READ;
        err_d     = BYTE_ERROR_CODE;
        ready_d   = 1'b0;
        timeout_d = 1'b0;
        if (state_q == IDLE) begin
            to_cnt_d = '0;
            if (fe_q && !fe_data_q && READ_ENABLE) begin
                state_d   = DATA;
                bit_cnt_d = '0;
            end
        end else if (!READ_ENABLE) begin
            state_d  = IDLE;
            to_cnt_d = '0;
        end else if (fe_q) begin
            to_cnt_d = '0;
            case (state_q)
                DATA: begin
                    shift_d[bit_cnt_q] = fe_data_q;
                    bit_cnt_d          = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7)
                        state_d = PARITY;
                end
                PARITY: begin
                    parity_d = fe_data_q;
                    state_d  = STOP;
                end
                STOP: begin
                    byte_d  = shift_q;
                    err_d   = {~fe_data_q, ~(^shift_q ^ parity_q)};
                    ready_d = 1'b1;
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        // Terminal count: the increment that would bring the counter to TIMEOUT_CYCLES-1.
        end else if (to_cnt_q == TW'(TIMEOUT_CYCLES - 2)) begin
            timeout_d = 1'b1;
            state_d   = IDLE;
            to_cnt_d  = '0;
        end else begin
            to_cnt_d = to_cnt_q + TW'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q         <= IDLE;
            shift_q         <= '0;
            bit_cnt_q       <= '0;
            to_cnt_q        <= '0;
            parity_q        <= 1'b0;
            BYTE_READ       <= '0;
            BYTE_ERROR_CODE <= '0;
            BYTE_READY      <= 1'b0;
            TIMEOUT         <= 1'b0;
        end else begin
            state_q         <= state_d;
            shift_q         <= shift_d;
            bit_cnt_q       <= bit_cnt_d;
            to_cnt_q        <= to_cnt_d;
            parity_q        <= parity_d;
            BYTE_READ       <= byte_d;
            BYTE_ERROR_CODE <= err_d;
            BYTE_READY      <= ready_d;
            TIMEOUT         <= timeout_d;
        end
    end

    assign BUSY = (state_q != IDLE);

endmodule

// File: doc/ps2_frame_receiver.md
Name: ps2_frame_receiver

Overview:
- Device-to-host PS/2 receiver: turns the mouse CLK/DATA line pair into validated bytes for the mouse master state machine inside the mouse transceiver.
- The transceiver owns the open-drain pins and passes the line levels in. This block has no bus access; its bytes become the status, X, Y and Z values that the bus peripheral exposes at 0xA0–0xA5.
- Detects the 11-bit frame (start, 8 data LSB-first, odd parity, stop), checks it, and flags byte-level errors and inter-edge timeouts.

Parameters:
- TIMEOUT_CYCLES, 50000, CLK cycles allowed between consecutive PS/2 clock falling edges inside a frame before the frame is aborted.
- FILTER_CYCLES, 8, consecutive low samples required to accept a PS/2 clock falling edge (used only with PS2_CLK_FILTER_EN).

Ports:
- CLK  in  1  system clock, 100 MHz
- RESET  in  1  synchronous, active-high reset
- CLK_MOUSE_IN  in  1  raw PS/2 clock line level (asynchronous)
- DATA_MOUSE_IN  in  1  raw PS/2 data line level (asynchronous)
- READ_ENABLE  in  1  high = receiver armed; low = frames ignored (transmitter owns the line)
- BYTE_READ  out  8  last received data byte; held until the next completed frame
- BYTE_ERROR_CODE  out  2  bit0 = parity error, bit1 = stop-bit error; valid with BYTE_READY
- BYTE_READY  out  1  one-cycle pulse when a frame completes
- TIMEOUT  out  1  one-cycle pulse when a frame is aborted by timeout
- BUSY  out  1  high while state is not IDLE

Behaviour:
- RESET is synchronous and active-high; clock is CLK. Reset values:
  - state = IDLE.
  - BYTE_READ, BYTE_ERROR_CODE, BYTE_READY, TIMEOUT and BUSY all 0.
  - Shift register, bit counter and timeout counter 0.
  - Synchroniser flops 1 (idle line high).
  - RESET mid-frame discards the partial frame; no BYTE_READY.
- Input sync: both lines pass through 2-FF synchronisers, then one extra registered copy of the clock for edge detection.
- Falling edge (FE): prev_clk = 1 and sync_clk = 0. Data is sampled from sync_data in the FE cycle.
- State IDLE:
  - FE with data = 0 and READ_ENABLE = 1 → DATA; bit counter = 0; timeout counter cleared.
  - FE with data = 1 is ignored; stay in IDLE.
- State DATA:
  - Each FE shifts data into bit[counter]; LSB arrives first.
  - After the 8th FE → PARITY.
- State PARITY: FE captures the parity bit → STOP.
- State STOP: FE captures the stop bit, then:
  - BYTE_READ <= shifted byte.
  - BYTE_ERROR_CODE[0] <= ~(^byte ^ parity), so the byte's XOR plus the parity bit must equal 1 (odd parity).
  - BYTE_ERROR_CODE[1] <= ~stop.
  - BYTE_READY pulses high in the cycle after that FE.
  - State returns to IDLE in that same following cycle.
  - Errored bytes are still delivered, with BYTE_READY and a non-zero error code.
- Latency: BYTE_READY rises 4 CLK cycles after the raw CLK_MOUSE_IN falling edge of the stop bit (2 sync + 1 edge register + 1 output register).
- Timeout:
  - The counter increments every cycle in any non-IDLE state and clears on each FE.
  - When it reaches TIMEOUT_CYCLES-1: TIMEOUT pulses for 1 cycle, state → IDLE, no BYTE_READY, BYTE_READ unchanged.
- READ_ENABLE:
  - Low in IDLE: start bits are ignored.
  - Deasserted in any other state: return to IDLE on the next cycle, no BYTE_READY, no TIMEOUT.
- Simultaneous events:
  - RESET overrides everything.
  - READ_ENABLE low overrides both FE and timeout.
  - An FE in the same cycle the timeout terminal count is reached: the FE wins and the counter clears.
- BUSY = (state != IDLE), registered with the state.

Optional Feature:
- Macro PS2_CLK_FILTER_EN.
- Defined:
  - A saturating low-counter runs on sync_clk and clears whenever sync_clk = 1.
  - An FE is recognised only in the cycle the counter reaches FILTER_CYCLES, after a prior high.
  - Data is sampled in that cycle.
  - Latency grows by FILTER_CYCLES-1 cycles.
  - Low glitches shorter than FILTER_CYCLES cycles produce no edge.
- Undefined: FE is the plain edge detector described under Behaviour, and no filter logic is synthesised.

Test Plan:
- Frame 0xFA, parity 1, stop 1, PS/2 clock period 60 µs, READ_ENABLE = 1 → BYTE_READ = 0xFA, ERROR = 2'b00, one BYTE_READY pulse 4 cycles after the stop-bit falling edge.
- Frame 0x00, parity 0 (bad), stop 1 → BYTE_READ = 0x00, ERROR = 2'b01. Then frame 0x08, parity 0, stop 0 → BYTE_READ = 0x08, ERROR = 2'b10.
- Start bit plus 4 data bits, then the clock is held high for 50000 cycles → TIMEOUT pulse exactly at cycle 49999 after the last FE, BUSY falls, no BYTE_READY. Next full frame 0xF4, parity 0 → BYTE_READ = 0xF4, ERROR = 2'b00.
- READ_ENABLE dropped after the 3rd data bit → BUSY = 0 the next cycle, no BYTE_READY/TIMEOUT. A full frame 0xAA sent with READ_ENABLE = 0 → no response.
- RESET asserted for 1 cycle after the 6th data bit, then frame 0x55, parity 1 → only one BYTE_READY, BYTE_READ = 0x55, ERROR = 2'b00.
- PS2_CLK_FILTER_EN defined: a 3-cycle low glitch on the clock during frame 0xFA → BYTE_READ = 0xFA, ERROR = 2'b00. Same stimulus without the macro → corrupted byte or error flagged.
